// File: rtl/banked_memory_pkg.sv
// Shared types and helpers for the banked_memory block.
package banked_memory_pkg;

  localparam int unsigned BYTE_WIDTH = 8;

  typedef enum logic {
    StIdle,
    StClearing
  } state_e;

  function automatic int unsigned strobe_count(int unsigned data_width);
    return data_width / BYTE_WIDTH;
  endfunction

endpackage

// File: rtl/banked_memory_if.sv
// Write/read/clear bus of banked_memory; the master drives requests, the memory is the slave.
interface banked_memory_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4
);
  import banked_memory_pkg::*;

  localparam int unsigned StrbWidth = strobe_count(DATA_WIDTH);

  logic                  clear;
  logic                  busy;
  logic                  write_enable;
  logic [StrbWidth-1:0]  write_strobe;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] read_address_a;
  logic [DATA_WIDTH-1:0] read_data_a;
  logic [ADDR_WIDTH-1:0] read_address_b;
  logic [DATA_WIDTH-1:0] read_data_b;

  modport master (
    output clear, write_enable, write_strobe, write_address, write_data,
    output read_address_a, read_address_b,
    input  busy, read_data_a, read_data_b
  );

  modport slave (
    input  clear, write_enable, write_strobe, write_address, write_data,
    input  read_address_a, read_address_b,
    output busy, read_data_a, read_data_b
  );

endinterface

// File: rtl/banked_memory_read_port.sv
// One read port: range check, Busy masking and, with BANKED_MEMORY_REG_READ_EN, an output register.
module banked_memory_read_port
  import banked_memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  busy_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  in_range;
  logic [DATA_WIDTH-1:0] data_d;

  assign in_range = 32'(addr_i) < DEPTH;
  assign data_d   = (busy_i || !in_range) ? '0 : word_i;

`ifdef BANKED_MEMORY_REG_READ_EN
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk_i ^ rst_ni;
  assign data_o         = data_d;
`endif

endmodule

// File: rtl/banked_memory.sv
// Word memory with byte-strobed write port, two read ports and a zeroing sweep on reset/Clear.
// Optional registered reads: define BANKED_MEMORY_REG_READ_EN.
module banked_memory
  import banked_memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  banked_memory_if.slave  bus
);

  localparam int unsigned           StrbWidth = strobe_count(DATA_WIDTH);
  localparam int unsigned           IdxWidth  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_addr_ok;
  logic                  wr_en;
  logic [IdxWidth-1:0]   wr_idx;
  logic [IdxWidth-1:0]   rd_idx_a;
  logic [IdxWidth-1:0]   rd_idx_b;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StClearing;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StClearing: begin
          ptr_q <= ptr_q + ADDR_WIDTH'(1);
          if (ptr_q == LastAddr) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StIdle: begin
          if (bus.clear) begin
            state_q <= StClearing;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StClearing;
          ptr_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign wr_addr_ok = 32'(bus.write_address) < DEPTH;
  // A Clear in the same cycle wins over the write.
  assign wr_en      = (state_q == StIdle) && bus.write_enable && !bus.clear && wr_addr_ok;
  assign wr_idx     = bus.write_address[IdxWidth-1:0];

  // Storage carries no reset; the sweep is what zeroes it.
  always_ff @(posedge clk_i) begin
    if (state_q == StClearing) begin
      mem_q[ptr_q[IdxWidth-1:0]] <= '0;
    end else if (wr_en) begin
      for (int unsigned k = 0; k < StrbWidth; k++) begin
        if (bus.write_strobe[k]) begin
          mem_q[wr_idx][k*BYTE_WIDTH +: BYTE_WIDTH] <= bus.write_data[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign rd_idx_a = bus.read_address_a[IdxWidth-1:0];
  assign rd_idx_b = bus.read_address_b[IdxWidth-1:0];

  banked_memory_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_read_port_a (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .busy_i (busy_q),
    .addr_i (bus.read_address_a),
    .word_i (mem_q[rd_idx_a]),
    .data_o (bus.read_data_a)
  );

  banked_memory_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_read_port_b (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .busy_i (busy_q),
    .addr_i (bus.read_address_b),
    .word_i (mem_q[rd_idx_b]),
    .data_o (bus.read_data_b)
  );

endmodule

// File: tb/tb_banked_memory.sv
// Self-checking bench for banked_memory: DEPTH=16 main instance plus a DEPTH=12 instance for bounds.
module tb_banked_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst16_n;
  logic rst12_n;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] sb_q[$];

  typedef struct {
    logic        we;
    logic [1:0]  strb;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs[13];

  banked_memory_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus16 ();
  banked_memory_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus12 ();

  banked_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(16)) dut16 (
    .clk_i  (clk),
    .rst_ni (rst16_n),
    .bus    (bus16)
  );

  banked_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12)) dut12 (
    .clk_i  (clk),
    .rst_ni (rst12_n),
    .bus    (bus12)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits until the read data for the presented addresses is valid.
  task automatic settle();
`ifdef BANKED_MEMORY_REG_READ_EN
    tick();
`else
    @(negedge clk);
`endif
  endtask

  task automatic read16(input string name, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [15:0] ea, input logic [15:0] eb);
    logic [31:0] e;
    bus16.read_address_a = ra;
    bus16.read_address_b = rb;
    sb_q.push_back({ea, eb});
    settle();
    e = sb_q.pop_front();
    check({name, "_a"}, bus16.read_data_a, e[31:16]);
    check({name, "_b"}, bus16.read_data_b, e[15:0]);
  endtask

  task automatic write16(input logic [1:0] strb, input logic [3:0] a, input logic [15:0] d);
    bus16.write_enable  = 1'b1;
    bus16.write_strobe  = strb;
    bus16.write_address = a;
    bus16.write_data    = d;
    tick();
    bus16.write_enable  = 1'b0;
  endtask

  initial begin
    bus16.clear = 1'b0; bus16.write_enable = 1'b0; bus16.write_strobe = '0;
    bus16.write_address = '0; bus16.write_data = '0;
    bus16.read_address_a = '0; bus16.read_address_b = '0;
    bus12.clear = 1'b0; bus12.write_enable = 1'b0; bus12.write_strobe = '0;
    bus12.write_address = '0; bus12.write_data = '0;
    bus12.read_address_a = '0; bus12.read_address_b = '0;
    rst16_n = 1'b0;
    rst12_n = 1'b0;

    vecs[0]  = '{1'b1, 2'b11, 4'd0,  16'hBEEF, 4'd0,  4'd3,  16'hBEEF, 16'h0000};
    vecs[1]  = '{1'b1, 2'b11, 4'd1,  16'hBEF0, 4'd1,  4'd2,  16'hBEF0, 16'h0000};
    vecs[2]  = '{1'b1, 2'b11, 4'd2,  16'hBEF1, 4'd2,  4'd1,  16'hBEF1, 16'hBEF0};
    vecs[3]  = '{1'b1, 2'b11, 4'd3,  16'hBEF2, 4'd3,  4'd0,  16'hBEF2, 16'hBEEF};
    vecs[4]  = '{1'b0, 2'b00, 4'd0,  16'h0000, 4'd0,  4'd3,  16'hBEEF, 16'hBEF2};
    vecs[5]  = '{1'b0, 2'b00, 4'd0,  16'h0000, 4'd1,  4'd2,  16'hBEF0, 16'hBEF1};
    vecs[6]  = '{1'b0, 2'b00, 4'd0,  16'h0000, 4'd2,  4'd1,  16'hBEF1, 16'hBEF0};
    vecs[7]  = '{1'b0, 2'b00, 4'd0,  16'h0000, 4'd3,  4'd0,  16'hBEF2, 16'hBEEF};
    vecs[8]  = '{1'b1, 2'b11, 4'd5,  16'h1234, 4'd5,  4'd5,  16'h1234, 16'h1234};
    vecs[9]  = '{1'b1, 2'b10, 4'd5,  16'hABCD, 4'd5,  4'd4,  16'hAB34, 16'h0000};
    vecs[10] = '{1'b1, 2'b00, 4'd5,  16'h5A5A, 4'd5,  4'd5,  16'hAB34, 16'hAB34};
    vecs[11] = '{1'b1, 2'b01, 4'd5,  16'h5678, 4'd5,  4'd0,  16'hAB78, 16'hBEEF};
    vecs[12] = '{1'b1, 2'b11, 4'd15, 16'hFFFF, 4'd15, 4'd14, 16'hFFFF, 16'h0000};

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bus16.busy, 16'h1);

    // Post-reset sweep: Busy for exactly 16 edges, reads masked to zero.
    rst16_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus16.read_address_a = 4'(i);
      bus16.read_address_b = 4'(15 - i);
      #1;
      check($sformatf("sweep_busy%0d", i), bus16.busy, 16'h1);
      check($sformatf("sweep_rda%0d", i), bus16.read_data_a, 16'h0000);
      check($sformatf("sweep_rdb%0d", i), bus16.read_data_b, 16'h0000);
      tick();
    end
    check("sweep_done", bus16.busy, 16'h0);
    for (int i = 0; i < 16; i++) begin
      read16($sformatf("swept%0d", i), 4'(i), 4'(15 - i), 16'h0000, 16'h0000);
    end

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].we) write16(vecs[i].strb, vecs[i].waddr, vecs[i].wdata);
      read16($sformatf("vec%0d", i), vecs[i].ra, vecs[i].rb, vecs[i].exp_a, vecs[i].exp_b);
    end

`ifdef BANKED_MEMORY_REG_READ_EN
    bus16.read_address_a = 4'd1;
    bus16.write_enable   = 1'b1;
    bus16.write_strobe   = 2'b11;
    bus16.write_address  = 4'd1;
    bus16.write_data     = 16'hCAFE;
    tick();
    bus16.write_enable   = 1'b0;
    check("reg_old", bus16.read_data_a, 16'hBEF0);
    tick();
    check("reg_new", bus16.read_data_a, 16'hCAFE);
`else
    bus16.read_address_a = 4'd0;
    bus16.write_enable   = 1'b1;
    bus16.write_strobe   = 2'b11;
    bus16.write_address  = 4'd0;
    bus16.write_data     = 16'h1111;
    #1;
    check("rdw_old", bus16.read_data_a, 16'hBEEF);
    tick();
    bus16.write_enable   = 1'b0;
    check("rdw_new", bus16.read_data_a, 16'h1111);
`endif

    // Clear collides with a write; later a write during Busy and a second Clear are both ignored.
    tick();
    bus16.clear         = 1'b1;
    bus16.write_enable  = 1'b1;
    bus16.write_strobe  = 2'b11;
    bus16.write_address = 4'd2;
    bus16.write_data    = 16'h5555;
    tick();
    bus16.clear         = 1'b0;
    bus16.write_enable  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("clear_busy%0d", i), bus16.busy, 16'h1);
      if (i == 10) begin
        bus16.write_enable  = 1'b1;
        bus16.write_address = 4'd7;
        bus16.write_data    = 16'h7777;
      end
      if (i == 8) bus16.clear = 1'b1;
      tick();
      bus16.write_enable = 1'b0;
      bus16.clear        = 1'b0;
    end
    check("clear_done", bus16.busy, 16'h0);
    read16("clear_a2_a7", 4'd2, 4'd7, 16'h0000, 16'h0000);
    read16("clear_a5_a15", 4'd5, 4'd15, 16'h0000, 16'h0000);

    // DEPTH=12: reset mid-sweep restarts a full sweep; out-of-range accesses are inert.
    tick();
    rst12_n = 1'b1;
    repeat (6) tick();
    check("d12_mid_busy", bus12.busy, 16'h1);
    rst12_n = 1'b0;
    tick();
    rst12_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check($sformatf("d12_busy%0d", i), bus12.busy, 16'h1);
      tick();
    end
    check("d12_done", bus12.busy, 16'h0);
    bus12.write_enable  = 1'b1;
    bus12.write_strobe  = 2'b11;
    bus12.write_address = 4'd13;
    bus12.write_data    = 16'hFFFF;
    tick();
    bus12.write_address = 4'd11;
    bus12.write_data    = 16'h0B0B;
    tick();
    bus12.write_enable  = 1'b0;
    bus12.read_address_a = 4'd13;
    bus12.read_address_b = 4'd11;
    settle();
    check("d12_rd13", bus12.read_data_a, 16'h0000);
    check("d12_rd11", bus12.read_data_b, 16'h0B0B);
    bus12.read_address_a = 4'd12;
    settle();
    check("d12_rd12", bus12.read_data_a, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
